// File: rtl/ram_bus_arbiter.sv
// Round-robin arbiter that places Ibex instruction-fetch and LSU requests onto one RAM port.
// Responses come back one cycle after the grant. Out-of-range accesses are answered with a bus error.
module ram_bus_arbiter #(
    parameter int unsigned  Depth    = 128,
    parameter logic [31:0]  BaseAddr = 32'h0010_0000,
    localparam int unsigned Aw       = $clog2(Depth)
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          instr_req_i,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,

    input  logic          data_req_i,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_addr_i,
    input  logic [31:0]   data_wdata_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    output logic [31:0]   data_rdata_o,
    output logic          data_err_o,

    output logic          ram_req_o,
    output logic          ram_write_o,
    output logic [Aw-1:0] ram_addr_o,
    output logic [31:0]   ram_wdata_o,
    output logic [31:0]   ram_wmask_o,
    input  logic [31:0]   ram_rdata_i
);

    localparam logic [31:0] WinBytes = 32'(Depth * 4);

    typedef enum logic {SRC_INSTR, SRC_DATA} src_e;

    src_e        last_q;
    logic [31:0] sel_addr;
    logic [31:0] offset;
    logic        in_range;
    logic [31:0] be_mask;

    always_comb begin
        // On a conflict, the master that was not granted most recently wins.
        instr_gnt_o = instr_req_i & (~data_req_i | (last_q == SRC_DATA));
        data_gnt_o  = data_req_i & ~instr_gnt_o;

        sel_addr = instr_gnt_o ? instr_addr_i : data_addr_i;
        offset   = sel_addr - BaseAddr;
        in_range = offset < WinBytes;

        be_mask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            be_mask[8*i +: 8] = {8{data_be_i[i]}};
        end

        ram_req_o   = (instr_gnt_o | data_gnt_o) & in_range;
        ram_write_o = ram_req_o & data_gnt_o & data_we_i;
        ram_addr_o  = offset[Aw+1:2];
        ram_wdata_o = data_wdata_i;
        ram_wmask_o = ram_write_o ? be_mask : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q         <= SRC_DATA;
            instr_rvalid_o <= 1'b0;
            instr_err_o    <= 1'b0;
            instr_rdata_o  <= '0;
            data_rvalid_o  <= 1'b0;
            data_err_o     <= 1'b0;
            data_rdata_o   <= '0;
        end else begin
            instr_rvalid_o <= instr_gnt_o;
            instr_err_o    <= instr_gnt_o & ~in_range;
            data_rvalid_o  <= data_gnt_o;
            data_err_o     <= data_gnt_o & ~in_range;

            // rdata holds between responses; writes and errors return zero.
            if (instr_gnt_o) begin
                instr_rdata_o <= in_range ? ram_rdata_i : '0;
            end
            if (data_gnt_o) begin
                data_rdata_o <= (in_range & ~data_we_i) ? ram_rdata_i : '0;
            end

            if (instr_gnt_o) begin
                last_q <= SRC_INSTR;
            end else if (data_gnt_o) begin
                last_q <= SRC_DATA;
            end
        end
    end

endmodule
